// File: rtl/npu_ld_out_bcast_buf.sv
// Shared-store broadcast buffer: one write port, two independent FWFT read ports; a slot frees once both ports pass it.
// Optional NPU_OUT_BUF_LOCKSTEP_EN ties port 1 to port 0 and pops only on a joint strobe.
module npu_ld_out_bcast_buf #(
  parameter int EW    = 8,
  parameter int DOTW  = 40,
  parameter int DEPTH = 64,
  parameter int ADDRW = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_wr_en,
  input  logic [EW*DOTW-1:0]   i_wr_din,
  output logic                 o_wr_rdy,
  input  logic                 i_ld_out_rd_en,
  output logic                 o_ld_out_rd_rdy,
  output logic [EW*DOTW-1:0]   o_ld_out_rd_dout,
  input  logic                 i_ld_out_rd_en1,
  output logic                 o_ld_out_rd_rdy1,
  output logic [EW*DOTW-1:0]   o_ld_out_rd_dout1,
  output logic [ADDRW:0]       o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  localparam int DW = EW * DOTW;
  localparam logic [ADDRW:0] FULL = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW:0] ONE  = (ADDRW+1)'(1);

  logic [DW-1:0]  mem [DEPTH];
  logic [ADDRW:0] wp, rp0, rp1, rp0_nxt, occ0, occ1;
  logic           pop0, wr_fire, unf_ev;

  assign occ0     = wp - rp0;
  assign occ1     = wp - rp1;
  assign o_count  = (occ0 > occ1) ? occ0 : occ1;
  assign o_wr_rdy = (o_count != FULL);
  assign wr_fire  = i_wr_en && o_wr_rdy;
  assign rp0_nxt  = pop0 ? rp0 + ONE : rp0;

  // Storage holds no reset; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wp[ADDRW-1:0]] <= i_wr_din;
  end

`ifdef NPU_OUT_BUF_LOCKSTEP_EN
  assign pop0   = i_ld_out_rd_en && i_ld_out_rd_en1 && o_ld_out_rd_rdy;
  assign unf_ev = (i_ld_out_rd_en != i_ld_out_rd_en1) ||
                  ((i_ld_out_rd_en || i_ld_out_rd_en1) && !o_ld_out_rd_rdy);
  assign rp1               = rp0;
  assign o_ld_out_rd_rdy1  = o_ld_out_rd_rdy;
  assign o_ld_out_rd_dout1 = o_ld_out_rd_dout;
`else
  logic           pop1;
  logic [ADDRW:0] rp1_nxt;

  assign pop0    = i_ld_out_rd_en && o_ld_out_rd_rdy;
  assign pop1    = i_ld_out_rd_en1 && o_ld_out_rd_rdy1;
  assign unf_ev  = (i_ld_out_rd_en && !o_ld_out_rd_rdy) ||
                   (i_ld_out_rd_en1 && !o_ld_out_rd_rdy1);
  assign rp1_nxt = pop1 ? rp1 + ONE : rp1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp1               <= '0;
      o_ld_out_rd_rdy1  <= 1'b0;
      o_ld_out_rd_dout1 <= '0;
    end else begin
      rp1              <= rp1_nxt;
      o_ld_out_rd_rdy1 <= (wp != rp1_nxt);
      if (wp != rp1_nxt) o_ld_out_rd_dout1 <= mem[rp1_nxt[ADDRW-1:0]];
    end
  end
`endif

  // Head loads from the pre-edge wp, so the entry written this edge is never read this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp               <= '0;
      rp0              <= '0;
      o_ld_out_rd_rdy  <= 1'b0;
      o_ld_out_rd_dout <= '0;
      o_overflow       <= 1'b0;
      o_underflow      <= 1'b0;
    end else begin
      if (wr_fire) wp <= wp + ONE;
      rp0             <= rp0_nxt;
      o_ld_out_rd_rdy <= (wp != rp0_nxt);
      if (wp != rp0_nxt) o_ld_out_rd_dout <= mem[rp0_nxt[ADDRW-1:0]];
      if (i_wr_en && !o_wr_rdy) o_overflow <= 1'b1;
      if (unf_ev) o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_npu_ld_out_bcast_buf.sv
// Bench for npu_ld_out_bcast_buf: vector table for the opening sequence, queue scoreboard for everything after.
module tb_npu_ld_out_bcast_buf;
  localparam int EW = 8, DOTW = 40, DEPTH = 64, ADDRW = 6, DW = EW * DOTW;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_wr_en, i_ld_out_rd_en, i_ld_out_rd_en1;
  logic [DW-1:0]   i_wr_din;
  logic            o_wr_rdy, o_ld_out_rd_rdy, o_ld_out_rd_rdy1, o_overflow, o_underflow;
  logic [DW-1:0]   o_ld_out_rd_dout, o_ld_out_rd_dout1;
  logic [ADDRW:0]  o_count;

  always #5 clk = ~clk;

  npu_ld_out_bcast_buf #(.EW(EW), .DOTW(DOTW), .DEPTH(DEPTH), .ADDRW(ADDRW)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_din(i_wr_din), .o_wr_rdy(o_wr_rdy),
    .i_ld_out_rd_en(i_ld_out_rd_en), .o_ld_out_rd_rdy(o_ld_out_rd_rdy),
    .o_ld_out_rd_dout(o_ld_out_rd_dout),
    .i_ld_out_rd_en1(i_ld_out_rd_en1), .o_ld_out_rd_rdy1(o_ld_out_rd_rdy1),
    .o_ld_out_rd_dout1(o_ld_out_rd_dout1),
    .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per-port queues of unread vectors plus the registered head view.
  logic [DW-1:0] mq0[$], mq1[$];
  bit            m_rdy0, m_rdy1, m_ovf, m_unf;
  logic [DW-1:0] m_d0, m_d1;

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         r0, r1;
    bit         e_r0, e_r1;
    logic [7:0] e_d0, e_d1;
    int         e_cnt;
    bit         e_unf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    return (mq0.size() > mq1.size()) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [DW-1:0] mk(input int seed);
    logic [DW-1:0] v;
    for (int j = 0; j < DOTW; j++) v[j*EW +: EW] = EW'(seed * 13 + j * 7);
    return v;
  endfunction

  task automatic model_reset();
    mq0.delete(); mq1.delete();
    m_rdy0 = 0; m_rdy1 = 0; m_ovf = 0; m_unf = 0;
    m_d0 = '0; m_d1 = '0;
  endtask

  task automatic model_step(input bit wr, input logic [DW-1:0] din, input bit r0, input bit r1);
    bit full, p0, p1;
    full = (m_count() == DEPTH);
`ifdef NPU_OUT_BUF_LOCKSTEP_EN
    p0 = r0 && r1 && m_rdy0;
    p1 = p0;
    if ((r0 != r1) || ((r0 || r1) && !m_rdy0)) m_unf = 1;
`else
    p0 = r0 && m_rdy0;
    p1 = r1 && m_rdy1;
    if ((r0 && !m_rdy0) || (r1 && !m_rdy1)) m_unf = 1;
`endif
    if (wr && full) m_ovf = 1;
    if (p0) void'(mq0.pop_front());
    if (p1) void'(mq1.pop_front());
    m_rdy0 = (mq0.size() != 0);
    if (m_rdy0) m_d0 = mq0[0];
    m_rdy1 = (mq1.size() != 0);
    if (m_rdy1) m_d1 = mq1[0];
    if (wr && !full) begin
      mq0.push_back(din);
      mq1.push_back(din);
    end
  endtask

  task automatic compare_all();
    chk("rdy0", 64'(o_ld_out_rd_rdy), 64'(m_rdy0));
    chk("rdy1", 64'(o_ld_out_rd_rdy1), 64'(m_rdy1));
    chkw("dout0", o_ld_out_rd_dout, m_d0);
    chkw("dout1", o_ld_out_rd_dout1, m_d1);
    chk("count", 64'(o_count), 64'(m_count()));
    chk("wr_rdy", 64'(o_wr_rdy), 64'(m_count() != DEPTH));
    chk("overflow", 64'(o_overflow), 64'(m_ovf));
    chk("underflow", 64'(o_underflow), 64'(m_unf));
  endtask

  task automatic cyc(input bit wr, input logic [DW-1:0] din, input bit r0, input bit r1);
    i_wr_en = wr; i_wr_din = din; i_ld_out_rd_en = r0; i_ld_out_rd_en1 = r1;
    @(posedge clk);
    #1;
    model_step(wr, din, r0, r1);
    compare_all();
    i_wr_en = 0; i_ld_out_rd_en = 0; i_ld_out_rd_en1 = 0;
  endtask

  initial begin
    vec_t tbl[14];
    tbl[0]  = '{1, 8'h01, 0, 0, 0, 0, 8'h00, 8'h00, 1, 0};
    tbl[1]  = '{1, 8'h02, 0, 0, 1, 1, 8'h01, 8'h01, 2, 0};
    tbl[2]  = '{1, 8'h03, 0, 0, 1, 1, 8'h01, 8'h01, 3, 0};
    tbl[3]  = '{1, 8'h04, 0, 0, 1, 1, 8'h01, 8'h01, 4, 0};
    tbl[4]  = '{0, 8'h00, 0, 0, 1, 1, 8'h01, 8'h01, 4, 0};
    tbl[5]  = '{0, 8'h00, 1, 0, 1, 1, 8'h02, 8'h01, 4, 0};
    tbl[6]  = '{0, 8'h00, 1, 0, 1, 1, 8'h03, 8'h01, 4, 0};
    tbl[7]  = '{0, 8'h00, 1, 0, 1, 1, 8'h04, 8'h01, 4, 0};
    tbl[8]  = '{0, 8'h00, 1, 0, 0, 1, 8'h04, 8'h01, 4, 0};
    tbl[9]  = '{0, 8'h00, 0, 1, 0, 1, 8'h04, 8'h02, 3, 0};
    tbl[10] = '{0, 8'h00, 0, 1, 0, 1, 8'h04, 8'h03, 2, 0};
    tbl[11] = '{0, 8'h00, 0, 1, 0, 1, 8'h04, 8'h04, 1, 0};
    tbl[12] = '{0, 8'h00, 0, 1, 0, 0, 8'h04, 8'h04, 0, 0};
    tbl[13] = '{0, 8'h00, 0, 1, 0, 0, 8'h04, 8'h04, 0, 1};

    rst = 0; i_wr_en = 0; i_wr_din = '0; i_ld_out_rd_en = 0; i_ld_out_rd_en1 = 0;
    model_reset();
    #2;
    compare_all();
    #10 rst = 1;

`ifndef NPU_OUT_BUF_LOCKSTEP_EN
    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].wr, {DOTW{tbl[i].d}}, tbl[i].r0, tbl[i].r1);
      chk("tbl_rdy0", 64'(o_ld_out_rd_rdy), 64'(tbl[i].e_r0));
      chk("tbl_rdy1", 64'(o_ld_out_rd_rdy1), 64'(tbl[i].e_r1));
      chkw("tbl_dout0", o_ld_out_rd_dout, {DOTW{tbl[i].e_d0}});
      chkw("tbl_dout1", o_ld_out_rd_dout1, {DOTW{tbl[i].e_d1}});
      chk("tbl_count", 64'(o_count), 64'(tbl[i].e_cnt));
      chk("tbl_underflow", 64'(o_underflow), 64'(tbl[i].e_unf));
    end
`endif

    // Fill to capacity, then overflow and the full-boundary cases.
    for (int i = 0; i < DEPTH; i++) cyc(1, mk(i), 0, 0);
    chk("full_wr_rdy", 64'(o_wr_rdy), 64'(0));
    chk("full_count", 64'(o_count), 64'(DEPTH));
    cyc(1, mk(99), 0, 0);
    chk("ovf_set", 64'(o_overflow), 64'(1));
    chk("ovf_count", 64'(o_count), 64'(DEPTH));
    cyc(0, '0, 1, 1);
    chk("pop_frees_count", 64'(o_count), 64'(DEPTH - 1));
    chk("pop_frees_wr_rdy", 64'(o_wr_rdy), 64'(1));
    cyc(1, mk(100), 0, 0);
    chk("refill_count", 64'(o_count), 64'(DEPTH));
    cyc(1, mk(101), 1, 1);
    chk("wr_pop_full_count", 64'(o_count), 64'(DEPTH - 1));
    chk("wr_pop_full_ovf", 64'(o_overflow), 64'(1));

    // Skewed random traffic: port 0 leads, then port 1 catches up and overtakes.
    for (int i = 0; i < 400; i++) begin
      bit wr, r0, r1;
      wr = ($urandom_range(0, 1) == 1);
      r0 = (i < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r1 = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(wr, mk(1000 + i), r0, r1);
    end

    repeat (2 * DEPTH + 4) cyc(0, '0, 1, 1);
    for (int i = 0; i < 10; i++) cyc(1, mk(200 + i), 0, 0);
    cyc(0, '0, 0, 0);
    chk("held_count", 64'(o_count), 64'(10));

    // Asynchronous reset between edges must clear outputs without waiting for a clock.
    rst = 0;
    #1;
    chk("rst_count", 64'(o_count), 64'(0));
    chk("rst_rdy0", 64'(o_ld_out_rd_rdy), 64'(0));
    chk("rst_rdy1", 64'(o_ld_out_rd_rdy1), 64'(0));
    chk("rst_ovf", 64'(o_overflow), 64'(0));
    chk("rst_unf", 64'(o_underflow), 64'(0));
    chk("rst_wr_rdy", 64'(o_wr_rdy), 64'(1));
    chkw("rst_dout0", o_ld_out_rd_dout, '0);
    chkw("rst_dout1", o_ld_out_rd_dout1, '0);
    model_reset();
    #2 rst = 1;
    cyc(1, mk(300), 0, 0);
    cyc(0, '0, 0, 0);
    chkw("post_rst_dout0", o_ld_out_rd_dout, mk(300));
    chkw("post_rst_dout1", o_ld_out_rd_dout1, mk(300));
    chk("post_rst_count", 64'(o_count), 64'(1));

`ifdef NPU_OUT_BUF_LOCKSTEP_EN
    cyc(0, '0, 1, 0);
    chk("lock_single_unf", 64'(o_underflow), 64'(1));
    chk("lock_single_count", 64'(o_count), 64'(1));
    chk("lock_single_rdy", 64'(o_ld_out_rd_rdy), 64'(1));
`else
    cyc(0, '0, 1, 0);
    chk("indep_pop0_count", 64'(o_count), 64'(1));
    chk("indep_pop0_rdy1", 64'(o_ld_out_rd_rdy1), 64'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_ld_out_bcast_buf.md
Name: npu_ld_out_bcast_buf

Overview:
- Output-side responder of the NPU loader's host read interface; owns `o_ld_out_rd_rdy`/`o_ld_out_rd_dout` and `o_ld_out_rd_rdy1`/`o_ld_out_rd_dout1`.
- Accepts result vectors from the loader write-back path and buffers them in one shared store.
- Presents the same vector stream on two independent first-word-fall-through read ports.
- A slot is reclaimed only after both ports have consumed it, so the two host readers may drift apart by up to DEPTH vectors.

Parameters:
- EW, 8, element width in bits.
- DOTW, 40, elements per vector; data width is EW*DOTW.
- DEPTH, 64, buffer entries; must be a power of two, at least 2.
- ADDRW, 6, log2(DEPTH); pointers are ADDRW+1 bits wide.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_wr_en  in  1  write strobe from loader.
- i_wr_din  in  EW*DOTW  vector to store.
- o_wr_rdy  out  1  buffer can accept a write this cycle.
- i_ld_out_rd_en  in  1  port 0 pop.
- o_ld_out_rd_rdy  out  1  port 0 has an unread vector.
- o_ld_out_rd_dout  out  EW*DOTW  port 0 head vector.
- i_ld_out_rd_en1  in  1  port 1 pop.
- o_ld_out_rd_rdy1  out  1  port 1 has an unread vector.
- o_ld_out_rd_dout1  out  EW*DOTW  port 1 head vector.
- o_count  out  ADDRW+1  occupied slots, i.e. wp minus the slower read pointer.
- o_overflow  out  1  sticky: write attempted while o_wr_rdy was 0.
- o_underflow  out  1  sticky: pop attempted while the port's rdy was 0.

Behaviour:
- Reset (rst=0, async):
  - wp, rp0 and rp1 clear to 0.
  - o_wr_rdy=1; both rd_rdy=0; both dout=0; o_count=0; o_overflow=0; o_underflow=0.
  - Release is synchronous to clk.
- Pointers and occupancy:
  - Pointers are ADDRW+1 bits; wrap is modulo 2*DEPTH; the MSB distinguishes full from empty.
  - occ_k = wp - rp_k.
  - used = max(occ0, occ1), which is o_count.
- o_wr_rdy = (used != DEPTH). It is derived from registered pointers only, with no same-cycle read bypass.
- Write handling:
  - Accepted when i_wr_en && o_wr_rdy: storage[wp[ADDRW-1:0]] <= i_wr_din and wp increments.
  - Refused when i_wr_en && !o_wr_rdy: data dropped, o_overflow set.
- o_ld_out_rd_rdy{,1} = (occ_k != 0), registered.
- Write-to-read latency:
  - A vector written at edge E shows rdy=1 and valid dout after edge E+1.
  - dout is a register loaded from storage, so read-during-write is never required.
- Pop on port k:
  - Happens when rd_en_k && rdy_k: rp_k increments.
  - On the next edge dout_k shows the following entry if present.
  - Otherwise dout_k holds its last value and rdy_k drops.
- rd_en_k while rdy_k=0 is ignored and sets o_underflow.
- Reclaim: a slot is freed when min-progress pointer passes it. Both ports popping the last shared entry in the same cycle frees it after one edge.
- Simultaneous write and pop with used=DEPTH: the write is refused and o_overflow set; the pop frees a slot, and o_wr_rdy=1 from the next cycle.
- Simultaneous write and pop with used<DEPTH: both take effect and o_count is unchanged.
- Port skew: one port may be up to DEPTH entries ahead; ports never block each other except via o_wr_rdy.
- Sticky flags clear only on reset.
- Reset mid-operation: all contents are discarded and outputs return to reset values immediately.

Optional Feature:
- Macro: NPU_OUT_BUF_LOCKSTEP_EN.
- Defined:
  - rp1 is tied to rp0, and o_ld_out_rd_rdy1 mirrors o_ld_out_rd_rdy.
  - A pop occurs only when i_ld_out_rd_en && i_ld_out_rd_en1 && rdy.
  - A pop strobe on exactly one port is ignored and sets o_underflow.
  - Storage-to-dout logic is shared between ports.
- Undefined: independent ports as described in Behaviour.

Test Plan:
- Write A0..A3 (0x01..0x04 replicated) on consecutive cycles with no pops.
  - Expect rdy on both ports 1 cycle after the first write.
  - Expect both dout=A0 and o_count=4.
- Pop port 0 four times while port 1 stays idle.
  - Expect dout0 sequence A0..A3, then rdy0=0.
  - Expect rdy1=1 with dout1=A0 and o_count=4.
  - Then pop port 1 four times: expect o_count=0.
- Fill 64 entries.
  - Expect o_wr_rdy=0 and o_count=64.
  - A 65th write is dropped and o_overflow=1.
  - Pop both ports once: expect o_wr_rdy=1 the next cycle.
- At full, pulse i_wr_en together with both pops.
  - Expect the write refused and o_overflow=1.
  - Expect o_count=63 after the edge.
- Pop port 1 when empty.
  - Expect o_underflow=1, rp1 unchanged, and no data change.
- Assert rst=0 mid-stream with 10 entries held.
  - Expect immediate o_count=0, both rdy=0 and flags cleared.
  - After release, expect a new write to read back correctly.
  - Lockstep build: a single-port pop is ignored and o_underflow=1.
